riscv_tag_exc_ctrl: RTL and testbench
=====================================

Name: riscv_tag_exc_ctrl

Overview:
- Central sequencer for DIFT tag-check exceptions.
- Collects per-instruction violation flags from the load, store, ALU and jump check units at writeback.
- Selects one violation by fixed priority and records its cause and PC.
- In trap mode, raises a held request to the core controller and stalls the pipeline until acknowledged. In log-only mode, records and counts violations without trapping.

Parameters:
- N_SRC, 4, number of check-unit exception inputs (index 0 = highest priority).
- CNT_WIDTH, 16, width of the saturating violation counter.
- CAUSE_W, $clog2(N_SRC), width of the cause index (derived; not to be overridden).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- check_exc_i  input  N_SRC  per-unit violation flags for the instruction in WB.
- check_valid_i  input  1  WB instruction valid and retiring this cycle.
- pc_i  input  32  PC of the WB instruction.
- trap_en_i  input  1  TCR trap-enable bit; 0 = log-only.
- flush_i  input  1  pipeline flush; WB instruction is squashed.
- exc_ack_i  input  1  controller has taken the tag exception.
- cnt_clr_i  input  1  clear counter and overflow (CSR write).
- exc_req_o  output  1  tag exception request to controller.
- stall_o  output  1  freeze pipeline.
- exc_cause_o  output  CAUSE_W  index of the recorded violating unit.
- exc_pc_o  output  32  PC of the recorded violation.
- viol_cnt_o  output  CNT_WIDTH  number of accepted violations.
- overflow_o  output  1  sticky: the counter saturated.

Behaviour:
- Reset (async, rst_n=0):
  - FSM = IDLE.
  - exc_req_o=0, exc_cause_o=0, exc_pc_o=0, viol_cnt_o=0, overflow_o=0.
  - stall_o=0.
- A violation is detected when check_valid_i=1, flush_i=0 and |check_exc_i=1, evaluated in IDLE only.
- Selection: the lowest set index of check_exc_i wins. Other simultaneous flags are discarded and counted as one violation.
- States are IDLE and REQ.
- IDLE, on a detected violation:
  - On the next edge, exc_cause_o and exc_pc_o are latched and the counter increments.
  - If trap_en_i=1: go to REQ.
  - Else: stay in IDLE (log-only).
- REQ:
  - exc_req_o=1, held stable together with exc_cause_o and exc_pc_o.
  - exc_ack_i=1 → IDLE at the next edge. exc_req_o drops that edge.
  - While in REQ: check_exc_i, check_valid_i and trap_en_i are ignored, and flush_i does not cancel the request (precise trap).
- exc_req_o is registered and first high one cycle after detection.
- stall_o is combinational and equals (state==REQ) OR (IDLE AND detected AND trap_en_i). It is high from the detection cycle through the ack cycle inclusive.
- exc_ack_i while in IDLE has no effect.
- Flush in the detection cycle: the violation is dropped. No latch, no count, no stall.
- Counter:
  - Saturating. At max (2^CNT_WIDTH-1), a further accepted violation holds the value and sets overflow_o.
  - overflow_o stays set until cnt_clr_i.
- cnt_clr_i:
  - Next edge: viol_cnt_o=0 and overflow_o=0.
  - Clear wins over a same-cycle increment; that violation is not counted, but its cause/PC are still latched and the FSM still transitions.
- exc_cause_o and exc_pc_o hold the last recorded violation indefinitely, in both modes.
- Reset asserted while in REQ: immediate return to IDLE with all outputs at their reset values. A pending violation is lost.

Test Plan:
- Reset, trap_en=1, check_exc=4'b0100, valid=1, pc=0x0000_1A40 → stall_o=1 same cycle; next cycle exc_req_o=1, exc_cause_o=2, exc_pc_o=0x1A40, viol_cnt_o=1; hold 5 cycles, then ack → exc_req_o=0 and stall_o=0 the cycle after ack.
- check_exc=4'b1010, trap_en=1 → exc_cause_o=1, viol_cnt_o increments by 1 only.
- trap_en=0, three back-to-back violations at pc 0x100/0x104/0x108 → exc_req_o and stall_o never assert; viol_cnt_o=3, exc_pc_o=0x108.
- Violation with flush_i=1 → no stall, no request, counter unchanged. Flush during REQ → exc_req_o stays 1 until ack.
- CNT_WIDTH=4: 16 violations → viol_cnt_o=15, overflow_o=1. cnt_clr_i together with a violation → viol_cnt_o=0, overflow_o=0, exc_pc_o updated.
- rst_n pulled low mid-REQ (asynchronously, between edges) → exc_req_o, stall_o, counter and overflow go to 0 immediately; the next violation after release is handled normally.

Source files
------------

// File: rtl/riscv_tag_exc_ctrl.sv
// DIFT tag-check exception sequencer: picks one WB violation by fixed priority, records cause/PC, counts it.
// Record/count update one edge after detection; in trap mode holds exc_req_o and stall_o until exc_ack_i.
module riscv_tag_exc_ctrl #(
  parameter  int N_SRC     = 4,
  parameter  int CNT_WIDTH = 16,
  localparam int CAUSE_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     check_exc_i,
  input  logic                 check_valid_i,
  input  logic [31:0]          pc_i,
  input  logic                 trap_en_i,
  input  logic                 flush_i,
  input  logic                 exc_ack_i,
  input  logic                 cnt_clr_i,
  output logic                 exc_req_o,
  output logic                 stall_o,
  output logic [CAUSE_W-1:0]   exc_cause_o,
  output logic [31:0]          exc_pc_o,
  output logic [CNT_WIDTH-1:0] viol_cnt_o,
  output logic                 overflow_o
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CAUSE_W-1:0] cause;
    logic [31:0]        pc;
  } exc_rec_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  exc_rec_t             rec_q, rec_d;
  logic [CAUSE_W-1:0]   sel_idx;
  logic                 sel_found;
  logic                 detected;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;

  // Lowest set flag wins; remaining simultaneous flags collapse into this one violation.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (check_exc_i[i] && !sel_found) begin
        sel_idx   = CAUSE_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Inputs are only sampled in IDLE, so an outstanding request is precise and cannot be cancelled.
  assign detected = (state_q == IDLE) && check_valid_i && !flush_i && sel_found;

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (detected) begin
          rec_d.cause = sel_idx;
          rec_d.pc    = pc_i;
          if (trap_en_i) begin
            state_d = REQ;
            stall_o = 1'b1;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (exc_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
    end
  end

  // Clear beats a same-cycle increment; saturation holds the count and raises the sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (detected) begin
      if (cnt_q == CNT_MAX) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign exc_req_o   = (state_q == REQ);
  assign exc_cause_o = rec_q.cause;
  assign exc_pc_o    = rec_q.pc;
  assign viol_cnt_o  = cnt_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_riscv_tag_exc_ctrl.sv
// Randomized and directed bench for riscv_tag_exc_ctrl with a transaction-level reference model.
module tb_riscv_tag_exc_ctrl;

  localparam int N_SRC = 4;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    check_exc;
  logic          check_valid;
  logic [31:0]   pc;
  logic          trap_en;
  logic          flush;
  logic          exc_ack;
  logic          cnt_clr;
  logic          exc_req;
  logic          stall;
  logic [1:0]    exc_cause;
  logic [31:0]   exc_pc;
  logic [CW-1:0] viol_cnt;
  logic          overflow;

  riscv_tag_exc_ctrl #(.N_SRC(N_SRC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .check_exc_i(check_exc), .check_valid_i(check_valid),
    .pc_i(pc), .trap_en_i(trap_en), .flush_i(flush), .exc_ack_i(exc_ack),
    .cnt_clr_i(cnt_clr), .exc_req_o(exc_req), .stall_o(stall), .exc_cause_o(exc_cause),
    .exc_pc_o(exc_pc), .viol_cnt_o(viol_cnt), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "waiting for ack" flag, last record, integer counter.
  bit          m_wait;
  logic [1:0]  m_cause;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_ovf;

  function automatic bit m_detect();
    return !m_wait && check_valid === 1'b1 && flush === 1'b0 && check_exc != 4'b0;
  endfunction

  function automatic bit m_stall();
    return m_wait || (m_detect() && trap_en === 1'b1);
  endfunction

  function automatic logic [1:0] first_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_cause = 0; m_pc = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit det;
    det = m_detect();
    if (m_wait) begin
      if (exc_ack) m_wait = 0;
    end else if (det) begin
      m_cause = first_set(check_exc);
      m_pc    = pc;
      m_wait  = trap_en;
    end
    if (cnt_clr) begin
      m_cnt = 0; m_ovf = 0;
    end else if (det) begin
      if (m_cnt == CMAX) m_ovf = 1;
      else m_cnt = m_cnt + 1;
    end
  endtask

  task automatic drive(input logic [3:0] e, input logic v, input logic [31:0] p,
                       input logic t, input logic f, input logic a, input logic c);
    check_exc = e; check_valid = v; pc = p; trap_en = t; flush = f; exc_ack = a; cnt_clr = c;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'b0, 0, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp += 6;
    if (exc_req !== 1'b0)   begin n_bad++; $display("FAIL reset_req got=%b exp=0", exc_req); end
    if (stall !== 1'b0)     begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    if (exc_cause !== 2'd0) begin n_bad++; $display("FAIL reset_cause got=%0d exp=0", exc_cause); end
    if (exc_pc !== 32'h0)   begin n_bad++; $display("FAIL reset_pc got=%h exp=0", exc_pc); end
    if (viol_cnt !== 4'd0)  begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", viol_cnt); end
    if (overflow !== 1'b0)  begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_trap();
    drive(4'b0100, 1, 32'h0000_1A40, 1, 0, 0, 0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL trap_stall_det got=%b exp=1", stall); end
    tick();
    n_cmp += 4;
    if (exc_req !== 1'b1)          begin n_bad++; $display("FAIL trap_req got=%b exp=1", exc_req); end
    if (exc_cause !== 2'd2)        begin n_bad++; $display("FAIL trap_cause got=%0d exp=2", exc_cause); end
    if (exc_pc !== 32'h0000_1A40)  begin n_bad++; $display("FAIL trap_pc got=%h exp=00001a40", exc_pc); end
    if (viol_cnt !== 4'd1)         begin n_bad++; $display("FAIL trap_cnt got=%0d exp=1", viol_cnt); end
    for (int i = 0; i < 5; i++) begin
      drive(4'($urandom_range(1, 15)), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 0, 0);
      tick();
      n_cmp += 4;
      if (exc_req !== 1'b1)         begin n_bad++; $display("FAIL trap_hold_req got=%b exp=1", exc_req); end
      if (stall !== 1'b1)           begin n_bad++; $display("FAIL trap_hold_stall got=%b exp=1", stall); end
      if (exc_pc !== 32'h0000_1A40) begin n_bad++; $display("FAIL trap_hold_pc got=%h exp=00001a40", exc_pc); end
      if (viol_cnt !== 4'd1)        begin n_bad++; $display("FAIL trap_hold_cnt got=%0d exp=1", viol_cnt); end
    end
    drive(4'b0, 0, 32'h0, 1, 0, 1, 0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL trap_ack_stall got=%b exp=1", stall); end
    tick();
    drive(4'b0, 0, 32'h0, 1, 0, 0, 0);
    #1;
    n_cmp += 2;
    if (exc_req !== 1'b0) begin n_bad++; $display("FAIL trap_post_req got=%b exp=0", exc_req); end
    if (stall !== 1'b0)   begin n_bad++; $display("FAIL trap_post_stall got=%b exp=0", stall); end
  endtask

  task automatic test_priority();
    drive(4'b1010, 1, 32'h0000_0200, 1, 0, 0, 0);
    tick();
    n_cmp += 3;
    if (exc_cause !== 2'd1) begin n_bad++; $display("FAIL prio_cause got=%0d exp=1", exc_cause); end
    if (viol_cnt !== 4'd2)  begin n_bad++; $display("FAIL prio_cnt got=%0d exp=2", viol_cnt); end
    if (exc_req !== 1'b1)   begin n_bad++; $display("FAIL prio_req got=%b exp=1", exc_req); end
    drive(4'b0, 0, 32'h0, 0, 0, 1, 0);
    tick();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL prio_ack got=%b exp=0", exc_req); end
  endtask

  task automatic test_log_only();
    drive(4'b0, 0, 32'h0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001 << i, 1, 32'h100 + 32'(4 * i), 0, 0, 0, 0);
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL log_stall got=%b exp=0", stall); end
      tick();
      n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL log_req got=%b exp=0", exc_req); end
    end
    n_cmp += 3;
    if (viol_cnt !== 4'd3)       begin n_bad++; $display("FAIL log_cnt got=%0d exp=3", viol_cnt); end
    if (exc_pc !== 32'h108)      begin n_bad++; $display("FAIL log_pc got=%h exp=00000108", exc_pc); end
    if (exc_cause !== 2'd2)      begin n_bad++; $display("FAIL log_cause got=%0d exp=2", exc_cause); end
  endtask

  task automatic test_flush();
    drive(4'b0001, 1, 32'h0000_0300, 1, 1, 0, 0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    n_cmp += 3;
    if (exc_req !== 1'b0)   begin n_bad++; $display("FAIL flush_req got=%b exp=0", exc_req); end
    if (viol_cnt !== 4'd3)  begin n_bad++; $display("FAIL flush_cnt got=%0d exp=3", viol_cnt); end
    if (exc_pc !== 32'h108) begin n_bad++; $display("FAIL flush_pc got=%h exp=00000108", exc_pc); end
    drive(4'b1000, 1, 32'h0000_0400, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, 1, 32'h0000_0500, 1, 1, 0, 0);
      tick();
      n_cmp += 2;
      if (exc_req !== 1'b1)   begin n_bad++; $display("FAIL flush_req_hold got=%b exp=1", exc_req); end
      if (exc_cause !== 2'd3) begin n_bad++; $display("FAIL flush_req_cause got=%0d exp=3", exc_cause); end
    end
    drive(4'b0, 0, 32'h0, 1, 1, 1, 0);
    tick();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL flush_req_ack got=%b exp=0", exc_req); end
  endtask

  task automatic test_overflow();
    drive(4'b0, 0, 32'h0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(4'($urandom_range(1, 15)), 1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0);
      tick();
      if (i == 14) begin
        n_cmp += 2;
        if (viol_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_edge_cnt got=%0d exp=15", viol_cnt); end
        if (overflow !== 1'b0)  begin n_bad++; $display("FAIL sat_edge_ovf got=%b exp=0", overflow); end
      end
    end
    n_cmp += 2;
    if (viol_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_cnt got=%0d exp=15", viol_cnt); end
    if (overflow !== 1'b1)  begin n_bad++; $display("FAIL sat_ovf got=%b exp=1", overflow); end
    drive(4'b0100, 1, 32'h0000_2000, 0, 0, 0, 1);
    tick();
    n_cmp += 3;
    if (viol_cnt !== 4'd0)     begin n_bad++; $display("FAIL clr_cnt got=%0d exp=0", viol_cnt); end
    if (overflow !== 1'b0)     begin n_bad++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
    if (exc_pc !== 32'h2000)   begin n_bad++; $display("FAIL clr_pc got=%h exp=00002000", exc_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom), 1'($urandom_range(0, 4) != 0), $urandom,
            1'($urandom), 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 30) == 0));
      #1;
      n_cmp++;
      if (stall !== m_stall()) begin n_bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, m_stall()); end
      tick();
      n_cmp += 5;
      if (exc_req !== m_wait)   begin n_bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, exc_req, m_wait); end
      if (exc_cause !== m_cause) begin n_bad++; $display("FAIL rnd_cause cyc=%0d got=%0d exp=%0d", i, exc_cause, m_cause); end
      if (exc_pc !== m_pc)      begin n_bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, exc_pc, m_pc); end
      if (viol_cnt !== 4'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, viol_cnt, m_cnt); end
      if (overflow !== m_ovf)   begin n_bad++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, overflow, m_ovf); end
    end
  endtask

  task automatic test_async_reset();
    drive(4'b0010, 1, 32'h0000_3000, 1, 0, 0, 0);
    tick();
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL arst_pre_req got=%b exp=1", exc_req); end
    drive(4'b0, 0, 32'h0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (exc_req !== 1'b0)   begin n_bad++; $display("FAIL arst_req got=%b exp=0", exc_req); end
    if (stall !== 1'b0)     begin n_bad++; $display("FAIL arst_stall got=%b exp=0", stall); end
    if (viol_cnt !== 4'd0)  begin n_bad++; $display("FAIL arst_cnt got=%0d exp=0", viol_cnt); end
    if (overflow !== 1'b0)  begin n_bad++; $display("FAIL arst_ovf got=%b exp=0", overflow); end
    if (exc_pc !== 32'h0)   begin n_bad++; $display("FAIL arst_pc got=%h exp=0", exc_pc); end
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(4'b1000, 1, 32'h0000_3100, 1, 0, 0, 0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL arst_post_stall got=%b exp=1", stall); end
    tick();
    n_cmp += 4;
    if (exc_req !== 1'b1)        begin n_bad++; $display("FAIL arst_post_req got=%b exp=1", exc_req); end
    if (exc_cause !== 2'd3)      begin n_bad++; $display("FAIL arst_post_cause got=%0d exp=3", exc_cause); end
    if (exc_pc !== 32'h3100)     begin n_bad++; $display("FAIL arst_post_pc got=%h exp=00003100", exc_pc); end
    if (viol_cnt !== 4'd1)       begin n_bad++; $display("FAIL arst_post_cnt got=%0d exp=1", viol_cnt); end
  endtask

  initial begin
    test_reset();
    test_trap();
    test_priority();
    test_log_only();
    test_flush();
    test_overflow();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout got=running exp=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
